// File: rtl/updown_count_monitor.sv
// Samples a mod-2^WIDTH counter bus and classifies each step as hold, +1, -1 or jump.
// Locks onto the counting direction; flags reversals, wraps and jump errors.
module updown_count_monitor #(
    parameter int WIDTH  = 3,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             dir_up,
    output logic [WIDTH-1:0] last_val,
    output logic             err_pulse,
    output logic             dir_chg_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RW = $clog2(LOCK_N + 1);

    localparam logic [1:0] S_NOREF  = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [WIDTH-1:0] ALL1     = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [RW-1:0]    LOCK_RUN = RW'(LOCK_N);

    logic [1:0]       state;
    logic [RW-1:0]    run;
    logic             cand_up;

    logic [WIDTH-1:0] delta;
    logic             is_hold;
    logic             is_up;
    logic             is_dn;
    logic             is_jump;
    logic             wrapped;
    logic [RW-1:0]    run_nx;
    logic             err_inc;

    assign delta   = cnt_in - last_val;
    assign is_hold = (delta == '0);
    assign is_up   = (delta == WIDTH'(1));
    assign is_dn   = !is_up && (delta == ALL1);
    assign is_jump = !is_hold && !is_up && !is_dn;
    assign wrapped = (is_up && last_val == ALL1) ||
                     (is_dn && last_val == '0);

    // A reversal during acquisition restarts the run at one step.
    assign run_nx  = (run == '0 || is_up == cand_up) ? run + 1'b1 : RW'(1);

    assign err_inc = sample_en && (state != S_NOREF) && is_jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_NOREF;
            run           <= '0;
            cand_up       <= 1'b0;
            locked        <= 1'b0;
            dir_up        <= 1'b0;
            last_val      <= '0;
            err_pulse     <= 1'b0;
            dir_chg_pulse <= 1'b0;
            wrap_pulse    <= 1'b0;
            err_cnt       <= '0;
        end else begin
            err_pulse     <= err_inc;
            dir_chg_pulse <= 1'b0;
            wrap_pulse    <= 1'b0;

            if (err_inc) begin
                if (clr_err)
                    err_cnt <= ERR_W'(1);
                else if (err_cnt != ERR_MAX)
                    err_cnt <= err_cnt + 1'b1;
            end else if (clr_err) begin
                err_cnt <= '0;
            end

            if (sample_en) begin
                last_val <= cnt_in;
                case (state)
                    S_NOREF: begin
                        state <= S_ACQ;
                        run   <= '0;
                    end
                    S_ACQ: begin
                        if (is_jump) begin
                            run <= '0;
                        end else if (!is_hold) begin
                            cand_up <= is_up;
                            if (run_nx >= LOCK_RUN) begin
                                state  <= S_LOCKED;
                                locked <= 1'b1;
                                dir_up <= is_up;
                                run    <= '0;
                            end else begin
                                run <= run_nx;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (is_jump) begin
                            state  <= S_ACQ;
                            locked <= 1'b0;
                            run    <= '0;
                        end else if (!is_hold) begin
                            wrap_pulse <= wrapped;
                            if (is_up != dir_up) begin
                                dir_chg_pulse <= 1'b1;
                                dir_up        <= is_up;
                            end
                        end
                    end
                    default: begin
                        state  <= S_NOREF;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
- Reader-side companion to the team's mod-2^W up/down counters.
- Samples a counter output bus on a strobe and classifies each step relative to the previous sample as hold, +1, -1 or illegal jump (all modulo 2^W).
- Locks onto the counting direction and reports direction changes, wrap-arounds and jump errors.
- Used on-chip and in benches as a checker for JK-based ripple/synchronous counters.

Parameters:
- WIDTH, 3, width of observed counter bus; modulus is 2^WIDTH.
- LOCK_N, 2, consecutive same-direction steps required to declare lock (>=1).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  when high at a clk edge, cnt_in is sampled; otherwise all state holds and pulses are 0.
- cnt_in  input  WIDTH  observed counter value; must be settled when sample_en is high.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  direction lock established.
- dir_up  output  1  locked direction: 1 = up, 0 = down; meaningful only while locked=1.
- last_val  output  WIDTH  most recently sampled value.
- err_pulse  output  1  one-cycle pulse on an illegal jump.
- dir_chg_pulse  output  1  one-cycle pulse when the direction reverses while locked.
- wrap_pulse  output  1  one-cycle pulse on a locked wrap: up from 2^W-1 to 0, or down from 0 to 2^W-1.
- err_cnt  output  ERR_W  saturating count of jump errors.

Behaviour:
- Reset values:
  - state=NOREF.
  - locked=0, dir_up=0, last_val=0.
  - all pulses=0, err_cnt=0.
  - internal run=0, cand_up=0.
- All outputs are registered. Effects of a sample appear in the cycle after the sampling edge. Pulses last exactly one cycle.
- Step classification, with delta=(cnt_in-last_val) mod 2^W:
  - HOLD if delta=0.
  - UP if delta=1.
  - DOWN if delta=2^W-1.
  - JUMP otherwise.
- Every sample loads last_val<=cnt_in.
- FSM (transitions only on sample_en=1):
  - NOREF:
    - Capture the value and go to ACQ with run=0.
    - No classification and no error on the first sample.
  - ACQ:
    - HOLD: no change.
    - UP/DOWN matching cand_up, or run=0: run+1, cand_up set to the step direction.
    - UP/DOWN opposite to cand_up with run>0: run=1, cand_up set to the new direction.
    - When the updated run reaches LOCK_N: go to LOCKED, locked=1, dir_up=cand_up, run cleared.
    - JUMP: err_pulse, err_cnt+1, run=0, stay in ACQ.
  - LOCKED:
    - HOLD: no change.
    - Same direction: stay; wrap_pulse if the step crossed the modulus boundary.
    - Opposite direction: dir_chg_pulse, dir_up flips, stay locked. wrap_pulse also fires if the reversed step crosses the boundary.
    - JUMP: err_pulse, err_cnt+1, locked=0, go to ACQ with run=0.
- With LOCK_N=1, the first UP/DOWN step in ACQ locks immediately.
- err_cnt:
  - Saturates at 2^ERR_W-1 and does not wrap.
  - clr_err alone clears it to 0.
  - clr_err in the same cycle as an increment gives err_cnt=1.
- Reset mid-operation returns everything to reset values on that edge, regardless of sample_en or clr_err.
- sample_en=0: state, last_val and err_cnt hold. Pulses are 0.

Test Plan:
- Reset, then WIDTH=3, LOCK_N=2, samples 7,0,1,2 -> locked=1 and dir_up=1 visible after the third sample. wrap_pulse=0 (7->0 occurs before lock). err_cnt=0.
- Locked up at 6, samples 7,0 -> wrap_pulse on the 7->0 sample only. Then samples 0,0 -> no pulses, state unchanged.
- Locked up at 3, samples 2,1 -> dir_chg_pulse once on the 3->2 step, dir_up=0, locked stays 1. Then 0,7 -> wrap_pulse on the 0->7 step.
- Locked at 2, sample 5 -> err_pulse, err_cnt=1, locked=0. Then samples 6,7 -> relock up after the second of them.
- ERR_W=2, force four jumps (0,3,6,1,4) -> err_cnt saturates at 3. A further jump with clr_err=1 gives err_cnt=1. clr_err alone gives 0.
- Assert reset while locked with err_cnt=2 and sample_en=1 -> next cycle all outputs at reset values. First subsequent sample causes no err_pulse even if non-adjacent.
